// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmit FSM states and the width/divider helpers
// used by both the transmit and receive paths.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Smallest r with 2**r >= n; written as a bounded loop so it folds at elaboration.
  function automatic int CeilLog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int BaudDiv(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side and line-side signals of the UART transmitter.
interface uart_tx_if #(
  parameter int WORD_LENGHT = 8
);
  logic [WORD_LENGHT-1:0] TX_in;
  logic                   send;
  logic                   TX_out;
  logic                   busy;
  logic                   done;

  modport master (output TX_in, output send, input TX_out, input busy, input done);
  modport slave  (input TX_in, input send, output TX_out, output busy, output done);
endinterface

// File: rtl/uart_tx_baud_tick_gen.sv
// Clock-enable generator: one-cycle tick every DIV cycles while enabled,
// counter held at zero whenever disabled.
module baud_tick_gen
  import uart_tx_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = CeilLog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a word on send and shifts out start, data (LSB
// first) and stop bits, each held for one baud period.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 50000000,
  parameter int BAUDRATE    = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int DIV   = BaudDiv(FREQUENCY, BAUDRATE);
  localparam int BIT_W = (CeilLog2(WORD_LENGHT) < 1) ? 1 : CeilLog2(WORD_LENGHT);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_LENGHT - 1);

  uart_tx_state_t         state_q, state_d;
  logic [WORD_LENGHT-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   tx_out_q, tx_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   baud_en;
  logic                   tick;

  // The counter sits at zero in IDLE, so accepting a frame also restarts bit timing.
  assign baud_en = (state_q != IDLE);

  baud_tick_gen #(
    .DIV (DIV)
  ) u_baud_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (baud_en),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_out_d  = tx_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (bus.send) begin
          shift_d  = bus.TX_in;
          state_d  = START;
          tx_out_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_out_d  = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d  = STOP;
            tx_out_d = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_out_d  = shift_d[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.TX_out = tx_out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter for the UART block; the transmit-side counterpart of the existing receive path.
- Accepts a parallel word on a `send` request and shifts out one frame, LSB first: start bit (0), WORD_LENGHT data bits, stop bit (1).
- Bit timing comes from an internal clock-enable tick derived from FREQUENCY/BAUDRATE; the block runs entirely on the system clock.
- Instantiated inside UART to drive TX_out.

Parameters:
- WORD_LENGHT, 8, data bits per frame (≥1).
- FREQUENCY, 50000000, system clock frequency in Hz.
- BAUDRATE, 9600, serial bit rate in bit/s. DIV = FREQUENCY/BAUDRATE, integer floor, must be ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- TX_in  input  WORD_LENGHT  word to transmit; sampled only when a frame is accepted.
- send  input  1  transmit request; level-sensitive, honoured only in IDLE.
- TX_out  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: rst==0 at a clk edge forces the following on the next edge:
  - state=IDLE, TX_out=1, busy=0, done=0;
  - baud counter=0, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame: the line returns high on that edge and no done pulse is produced.
- States: IDLE, START, DATA, STOP (enum).
- IDLE:
  - TX_out=1, busy=0.
  - If send==1 at edge N: latch TX_in into the shift register, clear the baud counter, go to START.
  - From edge N: TX_out=0 and busy=1 (one-cycle latency from request to start bit).
- Baud counter:
  - Counts 0..DIV-1 in every non-IDLE state.
  - tick=1 when count==DIV-1; the counter wraps to 0 on tick.
  - Each bit is held exactly DIV clk cycles.
- START: on tick, go to DATA; TX_out=shift[0]; bit counter=0.
- DATA:
  - On tick with bit counter < WORD_LENGHT-1: shift right by 1, increment the bit counter, TX_out=new shift[0].
  - On tick with bit counter == WORD_LENGHT-1: go to STOP; TX_out=1.
- STOP: on tick, go to IDLE; busy=0; done=1 for exactly that one cycle.
- Frame duration: (WORD_LENGHT+2)*DIV cycles from the start-bit edge to the edge where busy falls.
- Back-to-back frames:
  - With send held high, the next start bit begins one cycle after done.
  - That gives exactly one idle-high clk cycle between frames.
- send while busy is ignored and not queued.
- TX_in changes during a frame have no effect; only the latched copy is shifted.
- Counter widths:
  - Baud counter: CeilLog2(DIV) bits.
  - Bit counter: CeilLog2(WORD_LENGHT) bits, minimum 1.
  - No counter overflows in any legal parameter set.

Decomposition:
- Definitions package:
  - Add `uart_tx_state_t` (IDLE, START, DATA, STOP).
  - Reuse the existing CeilLog2 for all counter widths.
  - Add DIV computation as a function `BaudDiv(FREQUENCY, BAUDRATE)`, shared with the receive side.
- One sub-module: `baud_tick_gen`.
  - Parameter DIV; inputs clk, rst, enable; output tick.
  - Counter clears when enable==0.
- FSM and shift register stay in uart_tx.

Test Plan:
Simulation uses FREQUENCY=50000000, BAUDRATE=5000000, so DIV=10.
- Reset: hold rst=0 for 3 cycles with send=1 → TX_out=1, busy=0, done=0 throughout; no frame starts.
- Single frame: TX_in=8'hA5, send pulse of 1 cycle → TX_out bit sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; busy high for 100 cycles; done pulses once at cycle 100.
- Back-to-back: send held high with TX_in=8'h00, then 8'hFF → two frames separated by exactly 1 high cycle; data bits all 0, then all 1; two done pulses 101 cycles apart.
- Ignored request: during a frame of 8'h3C, pulse send with TX_in=8'hC3 at cycle 40 → the line carries only 8'h3C; a single done pulse; IDLE afterwards.
- Mid-frame reset: rst=0 at cycle 55 of a 8'h81 frame → TX_out=1 and busy=0 on the next edge; no done pulse; a new send after release produces a complete, correct frame.
- Width check: WORD_LENGHT=5, TX_in=5'h13 → bits 0,1,1,0,0,1,1; total 70 cycles.
